// File: rtl/memory_access.sv
// rtl/memory_access.sv - memory-access pipeline stage with data-memory request/response FSM
//
// Parameters:
//   DATA_SIZE  data/address width (byte lanes assume a 32-bit data word)
//   INST_SIZE  width of the PC+4 value
//   NUM_REGS   register count; destination index is $clog2(NUM_REGS) bits
// Ports:
//   i_aclk, i_areset_n                   clock, asynchronous active-low reset
//   i_valid, o_stall                     execute-stage handshake (upstream holds inputs while stalled)
//   i_cu_memread, i_cu_memwrite,
//   i_funct3                             load/store control and access size/sign
//   i_exe_data, i_store_data             ALU result / memory address, store value (rs2)
//   i_rdest, i_cu_regwrite,
//   i_cu_memtoreg, i_pcplus4             writeback pass-through fields
//   o_mem_req, o_mem_we, o_mem_addr,
//   o_mem_wdata, o_mem_be                data-memory request (address word-aligned)
//   i_mem_gnt, i_mem_rvalid, i_mem_rdata data-memory grant and read response
//   o_mem_data, o_exe_data, o_pcplus4,
//   o_rdest, o_cu_regwrite,
//   o_cu_memtoreg                        registered writeback outputs
//   o_mem_fault                          one-cycle pulse on misaligned/illegal access
module memory_access #(
  parameter int DATA_SIZE = 32,
  parameter int INST_SIZE = 32,
  parameter int NUM_REGS  = 32,
  localparam int RW       = $clog2(NUM_REGS)
) (
  input  logic                 i_aclk,
  input  logic                 i_areset_n,
  input  logic                 i_valid,
  output logic                 o_stall,
  input  logic                 i_cu_memread,
  input  logic                 i_cu_memwrite,
  input  logic [2:0]           i_funct3,
  input  logic [DATA_SIZE-1:0] i_exe_data,
  input  logic [DATA_SIZE-1:0] i_store_data,
  input  logic [RW-1:0]        i_rdest,
  input  logic                 i_cu_regwrite,
  input  logic [1:0]           i_cu_memtoreg,
  input  logic [INST_SIZE-1:0] i_pcplus4,
  output logic                 o_mem_req,
  output logic                 o_mem_we,
  output logic [DATA_SIZE-1:0] o_mem_addr,
  output logic [DATA_SIZE-1:0] o_mem_wdata,
  output logic [3:0]           o_mem_be,
  input  logic                 i_mem_gnt,
  input  logic                 i_mem_rvalid,
  input  logic [DATA_SIZE-1:0] i_mem_rdata,
  output logic [DATA_SIZE-1:0] o_mem_data,
  output logic [DATA_SIZE-1:0] o_exe_data,
  output logic [INST_SIZE-1:0] o_pcplus4,
  output logic [RW-1:0]        o_rdest,
  output logic                 o_cu_regwrite,
  output logic [1:0]           o_cu_memtoreg,
  output logic                 o_mem_fault
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t state_q, state_d;

  // Access captured at acceptance; the request is driven only from these.
  logic [DATA_SIZE-1:0] addr_q;
  logic [2:0]           funct3_q;
  logic                 we_q;
  logic [DATA_SIZE-1:0] wdata_q;
  logic [3:0]           be_q;
  logic [DATA_SIZE-1:0] exe_q;
  logic [INST_SIZE-1:0] pc_q;
  logic [RW-1:0]        rdest_q;
  logic                 regwrite_q;
  logic [1:0]           memtoreg_q;

  logic                 mem_op;
  logic                 illegal;
  logic [DATA_SIZE-1:0] st_wdata;
  logic [3:0]           st_be;
  logic [DATA_SIZE-1:0] ld_data;
  logic [7:0]           ld_byte;
  logic [15:0]          ld_half;

  logic accept_alu;
  logic accept_mem;
  logic fault_d;
  logic complete;
  logic complete_load;

  assign mem_op = i_cu_memread | i_cu_memwrite;

  // Alignment and encoding checks on the incoming access.
  always_comb begin
    illegal = 1'b0;
    if (i_cu_memread && i_cu_memwrite) begin
      illegal = 1'b1;
    end else if (i_cu_memread) begin
      case (i_funct3)
        3'b000, 3'b100: illegal = 1'b0;
        3'b001, 3'b101: illegal = i_exe_data[0];
        3'b010:         illegal = (i_exe_data[1:0] != 2'b00);
        default:        illegal = 1'b1;
      endcase
    end else if (i_cu_memwrite) begin
      case (i_funct3)
        3'b000:  illegal = 1'b0;
        3'b001:  illegal = i_exe_data[0];
        3'b010:  illegal = (i_exe_data[1:0] != 2'b00);
        default: illegal = 1'b1;
      endcase
    end
  end

  // Sub-word stores replicate the value across lanes so memory only
  // needs the byte enables to pick the right bytes.
  always_comb begin
    st_wdata = i_store_data;
    st_be    = 4'b1111;
    case (i_funct3[1:0])
      2'b00: begin
        st_wdata = {(DATA_SIZE/8){i_store_data[7:0]}};
        st_be    = 4'b0001 << i_exe_data[1:0];
      end
      2'b01: begin
        st_wdata = {(DATA_SIZE/16){i_store_data[15:0]}};
        st_be    = 4'b0011 << i_exe_data[1:0];
      end
      default: begin
        st_wdata = i_store_data;
        st_be    = 4'b1111;
      end
    endcase
  end

  // Load lane selection from the latched byte offset.
  assign ld_byte = i_mem_rdata[{addr_q[1:0], 3'b000} +: 8];
  assign ld_half = i_mem_rdata[{addr_q[1], 4'b0000} +: 16];

  always_comb begin
    ld_data = i_mem_rdata;
    case (funct3_q)
      3'b000:  ld_data = {{(DATA_SIZE-8){ld_byte[7]}}, ld_byte};
      3'b100:  ld_data = {{(DATA_SIZE-8){1'b0}}, ld_byte};
      3'b001:  ld_data = {{(DATA_SIZE-16){ld_half[15]}}, ld_half};
      3'b101:  ld_data = {{(DATA_SIZE-16){1'b0}}, ld_half};
      default: ld_data = i_mem_rdata;
    endcase
  end

  always_ff @(posedge i_aclk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    accept_alu    = 1'b0;
    accept_mem    = 1'b0;
    fault_d       = 1'b0;
    complete      = 1'b0;
    complete_load = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_valid) begin
          if (!mem_op) begin
            accept_alu = 1'b1;
          end else if (illegal) begin
            fault_d = 1'b1;
          end else begin
            accept_mem = 1'b1;
            state_d    = REQ;
          end
        end
      end
      REQ: begin
        // rvalid coincident with gnt belongs to no access of ours yet.
        if (i_mem_gnt) begin
          if (we_q) begin
            complete = 1'b1;
            state_d  = IDLE;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (i_mem_rvalid) begin
          complete      = 1'b1;
          complete_load = 1'b1;
          state_d       = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control outputs that must come out of reset in a known state.
  always_ff @(posedge i_aclk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      o_cu_regwrite <= 1'b0;
      o_mem_fault   <= 1'b0;
    end else begin
      o_mem_fault <= fault_d;
      if (accept_alu) begin
        o_cu_regwrite <= i_cu_regwrite;
      end else if (complete) begin
        o_cu_regwrite <= regwrite_q;
      end else begin
        o_cu_regwrite <= 1'b0;
      end
    end
  end

  // Datapath registers carry no reset; o_cu_regwrite qualifies them.
  always_ff @(posedge i_aclk) begin
    if (accept_mem) begin
      addr_q     <= i_exe_data;
      funct3_q   <= i_funct3;
      we_q       <= i_cu_memwrite;
      wdata_q    <= st_wdata;
      be_q       <= st_be;
      exe_q      <= i_exe_data;
      pc_q       <= i_pcplus4;
      rdest_q    <= i_rdest;
      regwrite_q <= i_cu_regwrite;
      memtoreg_q <= i_cu_memtoreg;
    end
    if (accept_alu) begin
      o_exe_data    <= i_exe_data;
      o_pcplus4     <= i_pcplus4;
      o_rdest       <= i_rdest;
      o_cu_memtoreg <= i_cu_memtoreg;
    end else if (complete) begin
      o_exe_data    <= exe_q;
      o_pcplus4     <= pc_q;
      o_rdest       <= rdest_q;
      o_cu_memtoreg <= memtoreg_q;
    end
    if (complete_load) begin
      o_mem_data <= ld_data;
    end
  end

  assign o_stall     = (state_q != IDLE);
  assign o_mem_req   = (state_q == REQ);
  assign o_mem_we    = o_mem_req & we_q;
  assign o_mem_be    = o_mem_req ? be_q : 4'b0000;
  assign o_mem_addr  = {addr_q[DATA_SIZE-1:2], 2'b00};
  assign o_mem_wdata = wdata_q;

endmodule

// File: tb/tb_memory_access.sv
// tb/tb_memory_access.sv - directed self-checking bench for memory_access
module tb_memory_access;

  logic        i_aclk = 1'b0;
  logic        i_areset_n;
  logic        i_valid;
  logic        o_stall;
  logic        i_cu_memread;
  logic        i_cu_memwrite;
  logic [2:0]  i_funct3;
  logic [31:0] i_exe_data;
  logic [31:0] i_store_data;
  logic [4:0]  i_rdest;
  logic        i_cu_regwrite;
  logic [1:0]  i_cu_memtoreg;
  logic [31:0] i_pcplus4;
  logic        o_mem_req;
  logic        o_mem_we;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic [3:0]  o_mem_be;
  logic        i_mem_gnt;
  logic        i_mem_rvalid;
  logic [31:0] i_mem_rdata;
  logic [31:0] o_mem_data;
  logic [31:0] o_exe_data;
  logic [31:0] o_pcplus4;
  logic [4:0]  o_rdest;
  logic        o_cu_regwrite;
  logic [1:0]  o_cu_memtoreg;
  logic        o_mem_fault;

  int n_cmp = 0;
  int n_err = 0;

  always #5 i_aclk = ~i_aclk;

  memory_access dut (
    .i_aclk        (i_aclk),
    .i_areset_n    (i_areset_n),
    .i_valid       (i_valid),
    .o_stall       (o_stall),
    .i_cu_memread  (i_cu_memread),
    .i_cu_memwrite (i_cu_memwrite),
    .i_funct3      (i_funct3),
    .i_exe_data    (i_exe_data),
    .i_store_data  (i_store_data),
    .i_rdest       (i_rdest),
    .i_cu_regwrite (i_cu_regwrite),
    .i_cu_memtoreg (i_cu_memtoreg),
    .i_pcplus4     (i_pcplus4),
    .o_mem_req     (o_mem_req),
    .o_mem_we      (o_mem_we),
    .o_mem_addr    (o_mem_addr),
    .o_mem_wdata   (o_mem_wdata),
    .o_mem_be      (o_mem_be),
    .i_mem_gnt     (i_mem_gnt),
    .i_mem_rvalid  (i_mem_rvalid),
    .i_mem_rdata   (i_mem_rdata),
    .o_mem_data    (o_mem_data),
    .o_exe_data    (o_exe_data),
    .o_pcplus4     (o_pcplus4),
    .o_rdest       (o_rdest),
    .o_cu_regwrite (o_cu_regwrite),
    .o_cu_memtoreg (o_cu_memtoreg),
    .o_mem_fault   (o_mem_fault)
  );

  task automatic drive_idle();
    i_valid       = 1'b0;
    i_cu_memread  = 1'b0;
    i_cu_memwrite = 1'b0;
    i_funct3      = 3'b000;
    i_exe_data    = 32'h0;
    i_store_data  = 32'h0;
    i_rdest       = 5'd0;
    i_cu_regwrite = 1'b0;
    i_cu_memtoreg = 2'd0;
    i_pcplus4     = 32'h0;
    i_mem_gnt     = 1'b0;
    i_mem_rvalid  = 1'b0;
    i_mem_rdata   = 32'h0;
  endtask

  task automatic drive_op(input logic rd_en, input logic wr_en, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] sdata,
                          input logic [4:0] rd, input logic regw, input logic [1:0] m2r,
                          input logic [31:0] pc4);
    i_valid       = 1'b1;
    i_cu_memread  = rd_en;
    i_cu_memwrite = wr_en;
    i_funct3      = f3;
    i_exe_data    = addr;
    i_store_data  = sdata;
    i_rdest       = rd;
    i_cu_regwrite = regw;
    i_cu_memtoreg = m2r;
    i_pcplus4     = pc4;
  endtask

  task automatic test_reset();
    drive_idle();
    i_areset_n = 1'b0;
    repeat (2) @(negedge i_aclk);
    n_cmp++; if (o_stall !== 1'b0) begin n_err++; $display("FAIL rst_stall got=%b exp=0", o_stall); end
    n_cmp++; if (o_mem_req !== 1'b0) begin n_err++; $display("FAIL rst_req got=%b exp=0", o_mem_req); end
    n_cmp++; if (o_cu_regwrite !== 1'b0) begin n_err++; $display("FAIL rst_regwrite got=%b exp=0", o_cu_regwrite); end
    n_cmp++; if (o_mem_fault !== 1'b0) begin n_err++; $display("FAIL rst_fault got=%b exp=0", o_mem_fault); end
    n_cmp++; if (o_mem_we !== 1'b0) begin n_err++; $display("FAIL rst_we got=%b exp=0", o_mem_we); end
    n_cmp++; if (o_mem_be !== 4'b0000) begin n_err++; $display("FAIL rst_be got=%b exp=0000", o_mem_be); end
    i_areset_n = 1'b1;
    @(negedge i_aclk);
    n_cmp++; if (o_stall !== 1'b0) begin n_err++; $display("FAIL rst_rel_stall got=%b exp=0", o_stall); end
  endtask

  task automatic test_alu();
    drive_op(1'b0, 1'b0, 3'b000, 32'h1234, 32'h0, 5'd5, 1'b1, 2'd0, 32'h0000_0044);
    @(negedge i_aclk);
    n_cmp++; if (o_exe_data !== 32'h1234) begin n_err++; $display("FAIL alu_exe got=%h exp=00001234", o_exe_data); end
    n_cmp++; if (o_rdest !== 5'd5) begin n_err++; $display("FAIL alu_rdest got=%0d exp=5", o_rdest); end
    n_cmp++; if (o_cu_regwrite !== 1'b1) begin n_err++; $display("FAIL alu_regwrite got=%b exp=1", o_cu_regwrite); end
    n_cmp++; if (o_stall !== 1'b0) begin n_err++; $display("FAIL alu_stall got=%b exp=0", o_stall); end
    n_cmp++; if (o_pcplus4 !== 32'h44) begin n_err++; $display("FAIL alu_pc4 got=%h exp=00000044", o_pcplus4); end
    drive_idle();
    @(negedge i_aclk);
    n_cmp++; if (o_cu_regwrite !== 1'b0) begin n_err++; $display("FAIL bubble_regwrite got=%b exp=0", o_cu_regwrite); end
  endtask

  // Byte load at 0x103 with the top byte 0x80; f3 picks signed or unsigned.
  // The LBU pass also offers a stray rvalid alongside gnt, which must be ignored.
  task automatic test_load_byte(input logic [2:0] f3, input logic [31:0] exp, input logic stray);
    drive_op(1'b1, 1'b0, f3, 32'h0000_0103, 32'h0, 5'd3, 1'b1, 2'd1, 32'h100);
    @(negedge i_aclk);
    n_cmp++; if (o_mem_req !== 1'b1) begin n_err++; $display("FAIL lb_req got=%b exp=1", o_mem_req); end
    n_cmp++; if (o_mem_addr !== 32'h100) begin n_err++; $display("FAIL lb_addr got=%h exp=00000100", o_mem_addr); end
    n_cmp++; if (o_mem_we !== 1'b0) begin n_err++; $display("FAIL lb_we got=%b exp=0", o_mem_we); end
    n_cmp++; if (o_stall !== 1'b1) begin n_err++; $display("FAIL lb_stall got=%b exp=1", o_stall); end
    n_cmp++; if (o_cu_regwrite !== 1'b0) begin n_err++; $display("FAIL lb_req_regwrite got=%b exp=0", o_cu_regwrite); end
    i_mem_gnt    = 1'b1;
    i_mem_rvalid = stray;
    i_mem_rdata  = 32'h0000_0000;
    @(negedge i_aclk);
    n_cmp++; if (o_mem_req !== 1'b0) begin n_err++; $display("FAIL lb_wait_req got=%b exp=0", o_mem_req); end
    n_cmp++; if (o_stall !== 1'b1) begin n_err++; $display("FAIL lb_wait_stall got=%b exp=1", o_stall); end
    i_mem_gnt    = 1'b0;
    i_mem_rvalid = 1'b1;
    i_mem_rdata  = 32'h8000_0000;
    @(negedge i_aclk);
    n_cmp++; if (o_mem_data !== exp) begin n_err++; $display("FAIL lb_data f3=%b got=%h exp=%h", f3, o_mem_data, exp); end
    n_cmp++; if (o_cu_regwrite !== 1'b1) begin n_err++; $display("FAIL lb_regwrite got=%b exp=1", o_cu_regwrite); end
    n_cmp++; if (o_rdest !== 5'd3) begin n_err++; $display("FAIL lb_rdest got=%0d exp=3", o_rdest); end
    n_cmp++; if (o_cu_memtoreg !== 2'd1) begin n_err++; $display("FAIL lb_memtoreg got=%0d exp=1", o_cu_memtoreg); end
    n_cmp++; if (o_stall !== 1'b0) begin n_err++; $display("FAIL lb_done_stall got=%b exp=0", o_stall); end
    drive_idle();
    @(negedge i_aclk);
  endtask

  task automatic test_store_half();
    drive_op(1'b0, 1'b1, 3'b001, 32'h0000_0102, 32'h0000_ABCD, 5'd0, 1'b0, 2'd0, 32'h200);
    for (int k = 0; k < 4; k++) begin
      @(negedge i_aclk);
      n_cmp++; if (o_mem_req !== 1'b1) begin n_err++; $display("FAIL sh_req cyc=%0d got=%b exp=1", k, o_mem_req); end
      n_cmp++; if (o_mem_we !== 1'b1) begin n_err++; $display("FAIL sh_we cyc=%0d got=%b exp=1", k, o_mem_we); end
      n_cmp++; if (o_mem_be !== 4'b1100) begin n_err++; $display("FAIL sh_be cyc=%0d got=%b exp=1100", k, o_mem_be); end
      n_cmp++; if (o_mem_wdata !== 32'hABCD_ABCD) begin n_err++; $display("FAIL sh_wdata cyc=%0d got=%h exp=abcdabcd", k, o_mem_wdata); end
      n_cmp++; if (o_mem_addr !== 32'h100) begin n_err++; $display("FAIL sh_addr cyc=%0d got=%h exp=00000100", k, o_mem_addr); end
      n_cmp++; if (o_stall !== 1'b1) begin n_err++; $display("FAIL sh_stall cyc=%0d got=%b exp=1", k, o_stall); end
      i_mem_gnt = (k == 3);
    end
    @(negedge i_aclk);
    n_cmp++; if (o_stall !== 1'b0) begin n_err++; $display("FAIL sh_done_stall got=%b exp=0", o_stall); end
    n_cmp++; if (o_mem_req !== 1'b0) begin n_err++; $display("FAIL sh_done_req got=%b exp=0", o_mem_req); end
    n_cmp++; if (o_mem_be !== 4'b0000) begin n_err++; $display("FAIL sh_done_be got=%b exp=0000", o_mem_be); end
    n_cmp++; if (o_pcplus4 !== 32'h200) begin n_err++; $display("FAIL sh_pc4 got=%h exp=00000200", o_pcplus4); end
    drive_idle();
    @(negedge i_aclk);
  endtask

  task automatic test_store_byte();
    drive_op(1'b0, 1'b1, 3'b000, 32'h0000_0101, 32'hFFFF_FF12, 5'd0, 1'b0, 2'd0, 32'h300);
    @(negedge i_aclk);
    n_cmp++; if (o_mem_be !== 4'b0010) begin n_err++; $display("FAIL sb_be got=%b exp=0010", o_mem_be); end
    n_cmp++; if (o_mem_wdata !== 32'h1212_1212) begin n_err++; $display("FAIL sb_wdata got=%h exp=12121212", o_mem_wdata); end
    i_mem_gnt = 1'b1;
    @(negedge i_aclk);
    n_cmp++; if (o_stall !== 1'b0) begin n_err++; $display("FAIL sb_done_stall got=%b exp=0", o_stall); end
    drive_idle();
    @(negedge i_aclk);
  endtask

  task automatic test_fault(input logic rd_en, input logic wr_en, input logic [2:0] f3,
                            input logic [31:0] addr);
    drive_op(rd_en, wr_en, f3, addr, 32'h0, 5'd6, 1'b1, 2'd1, 32'h400);
    @(negedge i_aclk);
    n_cmp++; if (o_mem_fault !== 1'b1) begin n_err++; $display("FAIL fault_pulse f3=%b addr=%h got=%b exp=1", f3, addr, o_mem_fault); end
    n_cmp++; if (o_mem_req !== 1'b0) begin n_err++; $display("FAIL fault_req got=%b exp=0", o_mem_req); end
    n_cmp++; if (o_stall !== 1'b0) begin n_err++; $display("FAIL fault_stall got=%b exp=0", o_stall); end
    n_cmp++; if (o_cu_regwrite !== 1'b0) begin n_err++; $display("FAIL fault_regwrite got=%b exp=0", o_cu_regwrite); end
    drive_idle();
    @(negedge i_aclk);
    n_cmp++; if (o_mem_fault !== 1'b0) begin n_err++; $display("FAIL fault_one_cycle got=%b exp=0", o_mem_fault); end
  endtask

  task automatic test_reset_in_wait();
    drive_op(1'b1, 1'b0, 3'b010, 32'h0000_0200, 32'h0, 5'd8, 1'b1, 2'd1, 32'h500);
    @(negedge i_aclk);
    i_mem_gnt = 1'b1;
    @(negedge i_aclk);
    n_cmp++; if (o_stall !== 1'b1) begin n_err++; $display("FAIL rw_in_wait got=%b exp=1", o_stall); end
    i_mem_gnt  = 1'b0;
    i_areset_n = 1'b0;
    #1;
    n_cmp++; if (o_stall !== 1'b0) begin n_err++; $display("FAIL rw_async_stall got=%b exp=0", o_stall); end
    n_cmp++; if (o_mem_req !== 1'b0) begin n_err++; $display("FAIL rw_async_req got=%b exp=0", o_mem_req); end
    @(negedge i_aclk);
    i_areset_n   = 1'b1;
    drive_idle();
    i_mem_rvalid = 1'b1;
    i_mem_rdata  = 32'hCAFE_F00D;
    @(negedge i_aclk);
    n_cmp++; if (o_cu_regwrite !== 1'b0) begin n_err++; $display("FAIL rw_regwrite got=%b exp=0", o_cu_regwrite); end
    n_cmp++; if (o_stall !== 1'b0) begin n_err++; $display("FAIL rw_stall got=%b exp=0", o_stall); end
    i_mem_rvalid = 1'b0;
    @(negedge i_aclk);
    n_cmp++; if (o_cu_regwrite !== 1'b0) begin n_err++; $display("FAIL rw_regwrite2 got=%b exp=0", o_cu_regwrite); end
  endtask

  task automatic test_back_to_back();
    drive_op(1'b1, 1'b0, 3'b010, 32'h0000_0300, 32'h0, 5'd7, 1'b1, 2'd1, 32'h600);
    @(negedge i_aclk);
    i_mem_gnt = 1'b1;
    @(negedge i_aclk);
    i_mem_gnt    = 1'b0;
    i_mem_rvalid = 1'b1;
    i_mem_rdata  = 32'hDEAD_BEEF;
    @(negedge i_aclk);
    n_cmp++; if (o_mem_data !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL b2b_lw_data got=%h exp=deadbeef", o_mem_data); end
    n_cmp++; if (o_rdest !== 5'd7) begin n_err++; $display("FAIL b2b_lw_rdest got=%0d exp=7", o_rdest); end
    n_cmp++; if (o_cu_regwrite !== 1'b1) begin n_err++; $display("FAIL b2b_lw_regwrite got=%b exp=1", o_cu_regwrite); end
    n_cmp++; if (o_exe_data !== 32'h300) begin n_err++; $display("FAIL b2b_lw_exe got=%h exp=00000300", o_exe_data); end
    n_cmp++; if (o_stall !== 1'b0) begin n_err++; $display("FAIL b2b_lw_stall got=%b exp=0", o_stall); end
    drive_idle();
    drive_op(1'b0, 1'b0, 3'b000, 32'h0000_0055, 32'h0, 5'd9, 1'b1, 2'd0, 32'h604);
    @(negedge i_aclk);
    n_cmp++; if (o_exe_data !== 32'h55) begin n_err++; $display("FAIL b2b_add_exe got=%h exp=00000055", o_exe_data); end
    n_cmp++; if (o_rdest !== 5'd9) begin n_err++; $display("FAIL b2b_add_rdest got=%0d exp=9", o_rdest); end
    n_cmp++; if (o_cu_regwrite !== 1'b1) begin n_err++; $display("FAIL b2b_add_regwrite got=%b exp=1", o_cu_regwrite); end
    n_cmp++; if (o_cu_memtoreg !== 2'd0) begin n_err++; $display("FAIL b2b_add_memtoreg got=%0d exp=0", o_cu_memtoreg); end
    drive_idle();
    @(negedge i_aclk);
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load_byte(3'b000, 32'hFFFF_FF80, 1'b0);
    test_load_byte(3'b100, 32'h0000_0080, 1'b1);
    test_store_half();
    test_store_byte();
    test_fault(1'b1, 1'b0, 3'b010, 32'h0000_0101);
    test_fault(1'b1, 1'b0, 3'b011, 32'h0000_0100);
    test_fault(1'b0, 1'b1, 3'b001, 32'h0000_0103);
    test_fault(1'b1, 1'b1, 3'b010, 32'h0000_0100);
    test_reset_in_wait();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
